// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the memory bus arbiter: bus op codes, field widths,
// arbiter state encodings and error codes.
package mem_bus_arbiter_pkg;

  localparam int IOSTATEWIDTH = 2;
  localparam int ADDRWIDTH    = 16;
  localparam int WORDWIDTH    = 32;
  localparam int ERRWIDTH     = 2;

  localparam logic [IOSTATEWIDTH-1:0] IDEL = 2'b00;
  localparam logic [IOSTATEWIDTH-1:0] RD   = 2'b01;
  localparam logic [IOSTATEWIDTH-1:0] WT   = 2'b10;

  localparam logic [ERRWIDTH-1:0] ERR_NONE        = 2'd0;
  localparam logic [ERRWIDTH-1:0] ERR_BUS_TIMEOUT = 2'd1;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  // Only RD and WT are requests; IDEL and the spare encoding are ignored.
  function automatic logic is_request(input logic [IOSTATEWIDTH-1:0] op);
    return (op == RD) || (op == WT);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid slot scanning from ptr upward,
// wrapping modulo NREQ. Returns the winner one-hot, its index and a hit flag.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int PTRW = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PTRW-1:0] ptr,
  output logic [NREQ-1:0] win_onehot,
  output logic [PTRW-1:0] win_idx,
  output logic            win_any
);

  logic [PTRW-1:0] cand [NREQ];

  // cand[k] is the slot examined k places after ptr.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    assign cand[gi] = PTRW'((int'(ptr) + gi) % NREQ);
  end

  always_comb begin
    win_idx    = '0;
    win_any    = 1'b0;
    win_onehot = '0;
    // Scan from the far end so the closest valid slot to ptr is kept last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (valid[cand[k]]) begin
        win_idx = cand[k];
        win_any = 1'b1;
      end
    end
    if (win_any) begin
      win_onehot[win_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter/sequencer sharing one memory port among NREQ caches.
// Define BUS_TIMEOUT_EN to abort transactions the memory never completes.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int PTRW    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NREQ*IOSTATEWIDTH-1:0] req_rw,
  input  logic [NREQ*ADDRWIDTH-1:0]    req_addr,
  input  logic [NREQ*WORDWIDTH-1:0]    req_wdata,
  output logic [NREQ-1:0]              req_done,
  output logic [WORDWIDTH-1:0]         req_rdata,
  output logic [NREQ-1:0]              grant,
  output logic [IOSTATEWIDTH-1:0]      mem_rw,
  output logic [ADDRWIDTH-1:0]         mem_addr,
  output logic [WORDWIDTH-1:0]         mem_wdata,
  input  logic [WORDWIDTH-1:0]         mem_rdata,
  input  logic                         mem_done,
  output logic [ERRWIDTH-1:0]          err
);

  if (NREQ < 2 || NREQ > 8 || PTRW != $clog2(NREQ) || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
    $error("mem_bus_arbiter: unsupported parameter combination");
  end

  arb_state_e              state_reg;
  logic [PTRW-1:0]         ptr_reg;
  logic [PTRW-1:0]         gidx_reg;
  logic [PTRW-1:0]         ptr_next;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         win_onehot;
  logic [PTRW-1:0]         win_idx;
  logic                    win_any;
  logic                    timeout_hit;

  logic [IOSTATEWIDTH-1:0] slot_rw    [NREQ];
  logic [ADDRWIDTH-1:0]    slot_addr  [NREQ];
  logic [WORDWIDTH-1:0]    slot_wdata [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
    assign slot_rw[gi]    = req_rw[gi*IOSTATEWIDTH +: IOSTATEWIDTH];
    assign slot_addr[gi]  = req_addr[gi*ADDRWIDTH +: ADDRWIDTH];
    assign slot_wdata[gi] = req_wdata[gi*WORDWIDTH +: WORDWIDTH];
    assign req_valid[gi]  = is_request(slot_rw[gi]);
  end

  rr_picker #(
    .NREQ (NREQ),
    .PTRW (PTRW)
  ) u_picker (
    .valid      (req_valid),
    .ptr        (ptr_reg),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .win_any    (win_any)
  );

  assign ptr_next = (gidx_reg == PTRW'(NREQ - 1)) ? '0 : gidx_reg + 1'b1;

`ifdef BUS_TIMEOUT_EN
  logic [7:0]          cnt_reg;
  logic [ERRWIDTH-1:0] err_reg;
  // cnt_reg counts completed BUSY cycles; the TIMEOUT-th one aborts.
  assign timeout_hit = (cnt_reg == 8'(TIMEOUT - 1));
  assign err         = err_reg;
`else
  assign timeout_hit = 1'b0;
  assign err         = ERR_NONE;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ARB_IDLE;
      ptr_reg   <= '0;
      gidx_reg  <= '0;
      grant     <= '0;
      req_done  <= '0;
      req_rdata <= '0;
      mem_rw    <= IDEL;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef BUS_TIMEOUT_EN
      cnt_reg   <= '0;
      err_reg   <= ERR_NONE;
`endif
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          if (win_any) begin
            gidx_reg  <= win_idx;
            grant     <= win_onehot;
            mem_rw    <= slot_rw[win_idx];
            mem_addr  <= slot_addr[win_idx];
            mem_wdata <= slot_wdata[win_idx];
            state_reg <= ARB_BUSY;
`ifdef BUS_TIMEOUT_EN
            cnt_reg   <= '0;
`endif
          end
        end
        ARB_BUSY: begin
          // mem_done takes priority over a timeout landing on the same edge.
          if (mem_done || timeout_hit) begin
            if (mem_done) begin
              if (mem_rw == RD) begin
                req_rdata <= mem_rdata;
              end
            end else begin
              req_rdata <= '0;
`ifdef BUS_TIMEOUT_EN
              err_reg   <= ERR_BUS_TIMEOUT;
`endif
            end
            req_done  <= grant;
            grant     <= '0;
            mem_rw    <= IDEL;
            ptr_reg   <= ptr_next;
            state_reg <= ARB_RESP;
          end
`ifdef BUS_TIMEOUT_EN
          else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
`endif
        end
        ARB_RESP: begin
          req_done  <= '0;
          state_reg <= ARB_IDLE;
        end
        default: begin
          state_reg <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus queues expected grants and
// completions, a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int NREQ    = 4;
  localparam int PTRW    = 2;
  localparam int TIMEOUT = 10;
  localparam int W       = IOSTATEWIDTH;

  logic                      clk;
  logic                      reset;
  logic [NREQ*W-1:0]         req_rw;
  logic [NREQ*ADDRWIDTH-1:0] req_addr;
  logic [NREQ*WORDWIDTH-1:0] req_wdata;
  logic [NREQ-1:0]           req_done;
  logic [WORDWIDTH-1:0]      req_rdata;
  logic [NREQ-1:0]           grant;
  logic [W-1:0]              mem_rw;
  logic [ADDRWIDTH-1:0]      mem_addr;
  logic [WORDWIDTH-1:0]      mem_wdata;
  logic [WORDWIDTH-1:0]      mem_rdata;
  logic                      mem_done;
  logic [ERRWIDTH-1:0]       err;

  mem_bus_arbiter #(
    .NREQ    (NREQ),
    .PTRW    (PTRW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_done  (req_done),
    .req_rdata (req_rdata),
    .grant     (grant),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done),
    .err       (err)
  );

  typedef struct {
    int                   slot;
    logic [W-1:0]         op;
    logic [ADDRWIDTH-1:0] addr;
    logic [WORDWIDTH-1:0] wdata;
    int                   gap;
  } gexp_t;

  typedef struct {
    int                   slot;
    logic [WORDWIDTH-1:0] rdata;
  } dexp_t;

  gexp_t gq[$];
  dexp_t dq[$];

  int checks          = 0;
  int errors          = 0;
  int cycle           = 0;
  int last_done_cycle = 0;
  int mem_lat         = 1;
  bit mem_never       = 1'b0;
  logic [WORDWIDTH-1:0] rd_value = '0;
  logic [ERRWIDTH-1:0]  exp_err  = ERR_NONE;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cycle++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int slot, input logic [W-1:0] op,
                       input logic [ADDRWIDTH-1:0] addr, input logic [WORDWIDTH-1:0] wd);
    req_rw[slot*W +: W]                 = op;
    req_addr[slot*ADDRWIDTH +: ADDRWIDTH] = addr;
    req_wdata[slot*WORDWIDTH +: WORDWIDTH] = wd;
  endtask

  task automatic set_op(input int slot, input logic [W-1:0] op);
    req_rw[slot*W +: W] = op;
  endtask

  task automatic expect_txn(input int slot, input logic [W-1:0] op,
                            input logic [ADDRWIDTH-1:0] addr, input logic [WORDWIDTH-1:0] wd,
                            input int gap, input logic [WORDWIDTH-1:0] rdata, input bit with_done);
    gexp_t g;
    dexp_t d;
    g.slot = slot; g.op = op; g.addr = addr; g.wdata = wd; g.gap = gap;
    gq.push_back(g);
    if (with_done) begin
      d.slot = slot; d.rdata = rdata;
      dq.push_back(d);
    end
  endtask

  task automatic wait_done(input int slot, input int budget, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (req_done[slot]) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_done: slot %0d got no req_done, required one within %0d cycles", slot, budget);
    end
  endtask

  task automatic idle_gap();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_grant"},     grant,     '0);
    chk({tag, "_req_done"},  req_done,  '0);
    chk({tag, "_req_rdata"}, req_rdata, '0);
    chk({tag, "_mem_rw"},    mem_rw,    IDEL);
    chk({tag, "_mem_addr"},  mem_addr,  '0);
    chk({tag, "_mem_wdata"}, mem_wdata, '0);
    chk({tag, "_err"},       err,       ERR_NONE);
  endtask

  // Memory model: asserts mem_done on the mem_lat-th BUSY cycle unless mem_never.
  initial begin
    int busy;
    busy      = 0;
    mem_done  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_rdata = rd_value;
      if (reset && mem_rw != IDEL && !mem_never) begin
        if (busy == mem_lat - 1) begin
          mem_done = 1'b1;
          busy     = 0;
        end else begin
          mem_done = 1'b0;
          busy++;
        end
      end else begin
        mem_done = 1'b0;
        busy     = 0;
      end
    end
  end

  // Monitor: compares grants and completions against the scoreboard queues.
  initial begin
    logic [NREQ-1:0] prev_grant;
    logic [NREQ-1:0] oh;
    bit              active;
    gexp_t           cur;
    dexp_t           d;
    prev_grant = '0;
    active     = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_grant = '0;
        active     = 1'b0;
      end else begin
        if (grant != prev_grant) begin
          if (grant != '0) begin
            if (gq.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_grant: got %b, required no grant", grant);
              active = 1'b0;
            end else begin
              cur = gq.pop_front();
              oh = '0;
              oh[cur.slot] = 1'b1;
              chk("grant_onehot", grant, oh);
              chk("grant_mem_fields", {mem_rw, mem_addr, mem_wdata}, {cur.op, cur.addr, cur.wdata});
              if (cur.gap >= 0) chk("grant_gap", cycle - last_done_cycle, cur.gap);
              active = 1'b1;
            end
          end else begin
            chk("release_mem_rw", mem_rw, IDEL);
            active = 1'b0;
          end
        end else if (active) begin
          chk("hold_mem_fields", {mem_rw, mem_addr, mem_wdata}, {cur.op, cur.addr, cur.wdata});
        end
        if (req_done != '0) begin
          if (dq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got %b, required no completion", req_done);
          end else begin
            d = dq.pop_front();
            oh = '0;
            oh[d.slot] = 1'b1;
            chk("done_onehot", req_done, oh);
            chk("done_rdata", req_rdata, d.rdata);
            $display("txn: slot %0d done, req_rdata=0x%0h", d.slot, req_rdata);
          end
          last_done_cycle = cycle;
        end
        prev_grant = grant;
      end
    end
  end

  initial begin
    int n;
    int nd;
    reset     = 1'b0;
    req_rw    = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b1;
    idle_gap();

    // All four slots write continuously: order 0,1,2,3,0 with one IDLE cycle between.
    mem_lat  = 1;
    rd_value = 32'hDEAD_BEEF;
    expect_txn(0, WT, 16'h0010, 32'h0000_1000, -1, 32'h0, 1'b1);
    expect_txn(1, WT, 16'h0011, 32'h0000_1001,  2, 32'h0, 1'b1);
    expect_txn(2, WT, 16'h0012, 32'h0000_1002,  2, 32'h0, 1'b1);
    expect_txn(3, WT, 16'h0013, 32'h0000_1003,  2, 32'h0, 1'b1);
    expect_txn(0, WT, 16'h0010, 32'h0000_1000,  2, 32'h0, 1'b1);
    for (int i = 0; i < NREQ; i++) drive(i, WT, 16'(16'h0010 + i), 32'(32'h1000 + i));
    nd = 0;
    for (int c = 0; c < 100 && nd < 5; c++) begin
      @(posedge clk); #1;
      if (req_done != '0) nd++;
    end
    chk("rr_done_count", nd, 5);
    for (int i = 0; i < NREQ; i++) set_op(i, IDEL);
    idle_gap();

    // Single read from slot 2.
    mem_lat  = 4;
    rd_value = 32'h0000_00A5;
    expect_txn(2, RD, 16'd5, 32'h0, -1, 32'h0000_00A5, 1'b1);
    drive(2, RD, 16'd5, 32'h0);
    @(posedge clk); #1;
    chk("rd_grant_next_edge", grant, 4'b0100);
    chk("rd_mem_rw_next_edge", mem_rw, RD);
    wait_done(2, 100, n);
    chk("rd_latency", n, 4);
    set_op(2, IDEL);
    idle_gap();

    // Slot 1 changes its address while BUSY; the latched address must hold.
    mem_lat  = 6;
    rd_value = 32'h0000_0777;
    expect_txn(1, RD, 16'd7, 32'h0, -1, 32'h0000_0777, 1'b1);
    drive(1, RD, 16'd7, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    drive(1, RD, 16'd9, 32'h0);
    @(posedge clk); #1;
    chk("addr_hold", mem_addr, 16'd7);
    wait_done(1, 100, n);
    set_op(1, IDEL);
    idle_gap();

    // Illegal encoding on slot 0 alongside a real read on slot 3.
    mem_lat  = 2;
    rd_value = 32'h0000_3333;
    expect_txn(3, RD, 16'h0033, 32'h0, -1, 32'h0000_3333, 1'b1);
    set_op(0, 2'b11);
    drive(3, RD, 16'h0033, 32'h0);
    @(posedge clk); #1;
    chk("illegal_grant_slot3", grant, 4'b1000);
    wait_done(3, 100, n);
    set_op(3, IDEL);
    repeat (6) @(posedge clk);
    #1;
    chk("illegal_never_granted", grant, 4'b0000);
    set_op(0, IDEL);
    idle_gap();

`ifdef BUS_TIMEOUT_EN
    // Memory never answers: abort after TIMEOUT BUSY cycles, sticky err.
    mem_never = 1'b1;
    expect_txn(2, WT, 16'h0044, 32'h0000_4444, -1, 32'h0, 1'b1);
    drive(2, WT, 16'h0044, 32'h0000_4444);
    wait_done(2, 100, n);
    chk("timeout_latency", n, TIMEOUT + 1);
    chk("timeout_err", err, ERR_BUS_TIMEOUT);
    set_op(2, IDEL);
    mem_never = 1'b0;
    idle_gap();
    mem_lat  = 3;
    rd_value = 32'h0000_5555;
    expect_txn(1, RD, 16'h0055, 32'h0, -1, 32'h0000_5555, 1'b1);
    drive(1, RD, 16'h0055, 32'h0);
    wait_done(1, 100, n);
    chk("after_timeout_latency", n, 4);
    chk("timeout_err_sticky", err, ERR_BUS_TIMEOUT);
    set_op(1, IDEL);
    exp_err = ERR_BUS_TIMEOUT;
    idle_gap();
`endif

    // Move ptr off zero, then hang a transaction and reset asynchronously.
    mem_lat  = 2;
    rd_value = 32'h0000_2222;
    expect_txn(2, RD, 16'h0022, 32'h0, -1, 32'h0000_2222, 1'b1);
    drive(2, RD, 16'h0022, 32'h0);
    wait_done(2, 100, n);
    set_op(2, IDEL);
    idle_gap();
    mem_never = 1'b1;
    expect_txn(1, RD, 16'h0011, 32'h0, -1, 32'h0, 1'b0);
    drive(1, RD, 16'h0011, 32'h0);
    repeat (8) @(posedge clk);
    #1;
    chk("hang_grant_held", grant, 4'b0010);
    chk("hang_err", err, exp_err);
    #1;
    reset = 1'b0;
    #1;
    check_reset_vals("async_reset");
    set_op(1, IDEL);
    mem_never = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    idle_gap();

    // After reset the pointer is back at 0: slot 0 beats slot 3.
    mem_lat  = 2;
    rd_value = 32'h0000_6060;
    expect_txn(0, RD, 16'h0060, 32'h0,          -1, 32'h0000_6060, 1'b1);
    expect_txn(3, WT, 16'h0063, 32'h0000_6363,   2, 32'h0000_6060, 1'b1);
    drive(0, RD, 16'h0060, 32'h0);
    drive(3, WT, 16'h0063, 32'h0000_6363);
    wait_done(0, 100, n);
    set_op(0, IDEL);
    wait_done(3, 100, n);
    set_op(3, IDEL);
    repeat (4) @(posedge clk);
    #1;

    chk("grant_queue_drained", gq.size(), 0);
    chk("done_queue_drained", dq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one memory port among NREQ cache controllers.
- Latches one request at a time, drives the memory port until the memory signals completion, then returns a one-cycle done pulse (plus read data) to the granted cache.
- Sits between the per-core caches and the memory model/controller. It replaces the fixed two-way prefer toggle with scalable fair arbitration.

Parameters:
- NREQ, 4, number of requesting caches (2..8).
- PTRW, 2, width of the round-robin pointer and grant index; must equal ceil(log2(NREQ)).
- TIMEOUT, 64, maximum BUSY cycles before abort (used only with BUS_TIMEOUT_EN).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_rw  in  NREQ*`IOSTATEWIDTH  per-requester op: `IDEL/`RD/`WT; slot i at [i*W +: W]
- req_addr  in  NREQ*`ADDRWIDTH  per-requester word address
- req_wdata  in  NREQ*`WORDWIDTH  per-requester write data
- req_done  out  NREQ  one-hot, one-cycle completion pulse
- req_rdata  out  `WORDWIDTH  read data broadcast; valid while req_done is high
- grant  out  NREQ  one-hot owner of the bus; 0 when idle
- mem_rw  out  `IOSTATEWIDTH  op to memory; `IDEL when no transaction
- mem_addr  out  `ADDRWIDTH  latched address
- mem_wdata  out  `WORDWIDTH  latched write data
- mem_rdata  in  `WORDWIDTH  memory read data, valid with mem_done
- mem_done  in  1  memory completion, sampled only in BUSY
- err  out  `ERRWIDTH  sticky error code; 0 = none

Behaviour:
- Reset (reset low, asynchronous):
  - State IDLE, ptr=0.
  - grant=0, req_done=0, req_rdata=0, mem_rw=`IDEL, mem_addr=0, mem_wdata=0, err=0.
  - Any in-flight transaction is dropped and never completed.
- Valid request: req_rw[i] equals `RD or `WT. `IDEL and any other encoding are not requests and are never granted.
- Round-robin pick: the first valid i scanning ptr, ptr+1, …, wrapping mod NREQ.
- State machine (all outputs registered):
  - IDLE: if any valid request, latch the winner's rw/addr/wdata, set grant[g]=1, set mem_rw to the latched op, go to BUSY. Otherwise stay.
  - BUSY: hold mem_rw/addr/wdata/grant constant. Requester inputs are ignored; changes mid-transaction have no effect. On mem_done=1:
    - if the op was RD, capture req_rdata=mem_rdata;
    - set req_done[g]=1, mem_rw=`IDEL, grant=0, ptr=(g+1) mod NREQ;
    - go to RESP.
  - RESP: req_done is high for exactly this cycle, then cleared. Go to IDLE.
- Latency:
  - Request visible before edge k → mem_rw non-idle from edge k.
  - mem_done sampled at edge m → req_done high from edge m to edge m+1.
  - Minimum request-to-done is 2 edges; minimum back-to-back spacing between grants is 3 cycles.
- Requester protocol: keep req_rw stable until req_done is seen; drop to `IDEL at the next edge or issue a new op. Because RESP intervenes, a requester that drops req_rw on its done is never re-granted spuriously.
- mem_done in IDLE/RESP is ignored.
- req_rdata holds its last value outside done pulses; it is not updated on WT.
- Simultaneous requests from all NREQ slots: each is served exactly once per NREQ grants (no starvation).
- ptr wrap: with NREQ=4 and g=3, the next ptr is 0.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- With it defined:
  - An 8-bit cycle counter runs in BUSY. If it reaches TIMEOUT without mem_done, the transaction aborts: req_done[g] pulses, req_rdata=0, mem_rw=`IDEL, ptr advances, and err is set to 1 (sticky until reset).
  - mem_done arriving on the same edge the count reaches TIMEOUT wins: normal completion, no error.
- Without it: no counter, BUSY waits indefinitely, and err is constant 0.

Decomposition:
- Shared def header: `IOSTATEWIDTH, `IDEL, `RD, `WT, `ADDRWIDTH, `WORDWIDTH, `ERRWIDTH, plus new constants for the state encodings (ARB_IDLE, ARB_BUSY, ARB_RESP) and the error code ERR_BUS_TIMEOUT=1.
- One sub-module, rr_picker: combinational circuit taking the valid vector and ptr, producing a one-hot winner and its index. It is reused by any future arbiter.

Test Plan:
- Single RD from slot 2, addr 5; memory returns 0xA5 after 4 cycles → grant=4'b0100 and mem_rw=`RD the edge after the request; req_done=4'b0100 for one cycle with req_rdata=0xA5.
- All 4 slots request WT continuously from reset → grant order 0,1,2,3,0; each req_done pulse is followed by the next grant exactly 1 cycle later (IDLE).
- Slot 1 changes req_addr from 7 to 9 while BUSY → mem_addr stays 7 until done.
- Slot 0 presents the illegal encoding 2'b11 while slot 3 requests RD → only slot 3 is granted; slot 0 is never granted.
- Assert reset low mid-BUSY, then release → all outputs at reset values immediately (asynchronously); no req_done pulse; the next grant starts from slot 0.
- BUS_TIMEOUT_EN, TIMEOUT=10, memory never asserts done → abort after 10 BUSY cycles, req_done pulses, err=1 and stays 1; the next request completes normally.
